// File: rtl/logic_bit_pkg.sv
// Shared types and default sizing for the logic_bit_monitor slice.
// Latency: n/a (types only).
// Backpressure: n/a.
package logic_bit_pkg;

  typedef enum logic [1:0] {
    FILL_ZERO = 2'd0,
    FILL_ONE  = 2'd1,
    FILL_HOLD = 2'd2
  } fill_mode_e;

  typedef enum logic {
    ARMED = 1'b0,
    TRACK = 1'b1
  } mon_state_e;

  localparam int DEF_WIDTH     = 4;
  localparam int DEF_DEPTH     = 4;
  localparam int DEF_TS_W      = 8;
  localparam int DEF_CNT_W     = 8;
  localparam int DEF_FILL_MODE = 0;

endpackage

// File: rtl/lbm_fifo.sv
// Generic synchronous show-ahead FIFO for change records.
// Latency: a push is visible on rd_* the cycle after it is accepted (no bypass).
// Backpressure: rd_dat holds while rd_vld && !rd_rdy; a push while full is accepted only with a same-cycle pop.
module lbm_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_vld,
  input  logic [DATA_W-1:0] wr_dat,
  output logic              full,
  output logic              rd_vld,
  input  logic              rd_rdy,
  output logic [DATA_W-1:0] rd_dat
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]   wr_ptr;
  logic [ADDR_W:0]   rd_ptr;
  logic              pop;
  logic              push;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign full   = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                  (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign rd_vld = (wr_ptr != rd_ptr);
  assign pop    = rd_vld && rd_rdy;
  assign push   = wr_vld && (!full || pop);
  assign rd_dat = mem[rd_ptr[ADDR_W-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[ADDR_W-1:0]] <= wr_dat;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/logic_bit_monitor.sv
// Samples a 4-state bus, emits a sanitized 2-state value, counts X/Z samples and queues timestamped change records.
// Latency: dout/dout_xz update one edge after din_valid; a record appears on evt_* the cycle after its push.
// Backpressure: evt_* held while evt_valid && !evt_ready; records arriving at a full FIFO are dropped and counted.
module logic_bit_monitor
  import logic_bit_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int TS_W      = DEF_TS_W,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int FILL_MODE = DEF_FILL_MODE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             clear,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] dout_xz,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [WIDTH-1:0] evt_value,
  output logic [WIDTH-1:0] evt_xz,
  output logic [TS_W-1:0]  evt_ts,
  output logic [CNT_W-1:0] xz_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             overflow
);

  localparam int               REC_W   = 2*WIDTH + TS_W;
  localparam fill_mode_e       FILL    = fill_mode_e'(FILL_MODE[1:0]);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  mon_state_e       state_q;
  mon_state_e       state_d;
  logic [WIDTH-1:0] san;
  logic [WIDTH-1:0] xz_mask;
  logic [TS_W-1:0]  ts;
  logic             push;
  logic             fifo_full;
  logic             drop;
  logic [REC_W-1:0] rec_out;

  // Case-inequality only sees X/Z in simulation; in silicon xz_mask is constant zero.
  always_comb begin
    xz_mask = '0;
    san     = '0;
    for (int i = 0; i < WIDTH; i++) begin
      xz_mask[i] = (din[i] !== 1'b0) && (din[i] !== 1'b1);
      if (!xz_mask[i]) begin
        san[i] = din[i];
      end else begin
        case (FILL)
          FILL_ONE:  san[i] = 1'b1;
          FILL_HOLD: san[i] = dout[i];
          default:   san[i] = 1'b0;
        endcase
      end
    end
  end

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    case (state_q)
      ARMED: begin
        if (din_valid) begin
          push    = 1'b1;
          state_d = TRACK;
        end
      end
      TRACK: begin
        push = din_valid && ((san != dout) || (xz_mask != dout_xz));
      end
      default: state_d = ARMED;
    endcase
  end

  assign drop = push && fifo_full && !(evt_valid && evt_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ARMED;
      ts       <= '0;
      dout     <= '0;
      dout_xz  <= '0;
      xz_cnt   <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      state_q <= state_d;
      ts      <= ts + 1'b1;
      if (din_valid) begin
        dout    <= san;
        dout_xz <= xz_mask;
      end
      // clear takes priority over any coincident increment.
      if (clear) begin
        xz_cnt   <= '0;
        drop_cnt <= '0;
        overflow <= 1'b0;
      end else begin
        if (din_valid && (|xz_mask) && (xz_cnt != CNT_MAX)) xz_cnt <= xz_cnt + 1'b1;
        if (drop) begin
          overflow <= 1'b1;
          if (drop_cnt != CNT_MAX) drop_cnt <= drop_cnt + 1'b1;
        end
      end
    end
  end

  lbm_fifo #(
    .DATA_W (REC_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_vld (push),
    .wr_dat ({san, xz_mask, ts}),
    .full   (fifo_full),
    .rd_vld (evt_valid),
    .rd_rdy (evt_ready),
    .rd_dat (rec_out)
  );

  assign {evt_value, evt_xz, evt_ts} = rec_out;

endmodule

// File: tb/tb_logic_bit_monitor.sv
// Directed bench for logic_bit_monitor: a FILL_MODE=0 instance and a FILL_MODE=2 instance share one stimulus.
module tb_logic_bit_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] din = 4'h0;
  logic       din_valid = 1'b0;
  logic       clear = 1'b0;
  logic       evt_ready = 1'b0;

  logic [3:0] dout, dout_xz, evt_value, evt_xz;
  logic       evt_valid, overflow;
  logic [7:0] evt_ts, xz_cnt, drop_cnt;

  logic [3:0] h_dout, h_dout_xz, h_evt_value, h_evt_xz;
  logic       h_evt_valid, h_overflow;
  logic [7:0] h_evt_ts, h_xz_cnt, h_drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] tb_ts = 8'd0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) tb_ts <= 8'd0;
    else     tb_ts <= tb_ts + 8'd1;
  end

  logic_bit_monitor #(.WIDTH(4), .DEPTH(4), .TS_W(8), .CNT_W(8), .FILL_MODE(0)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clear(clear),
    .dout(dout), .dout_xz(dout_xz), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_value(evt_value), .evt_xz(evt_xz), .evt_ts(evt_ts),
    .xz_cnt(xz_cnt), .drop_cnt(drop_cnt), .overflow(overflow)
  );

  logic_bit_monitor #(.WIDTH(4), .DEPTH(4), .TS_W(8), .CNT_W(8), .FILL_MODE(2)) dut_h (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clear(clear),
    .dout(h_dout), .dout_xz(h_dout_xz), .evt_valid(h_evt_valid), .evt_ready(evt_ready),
    .evt_value(h_evt_value), .evt_xz(h_evt_xz), .evt_ts(h_evt_ts),
    .xz_cnt(h_xz_cnt), .drop_cnt(h_drop_cnt), .overflow(h_overflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++; if (dout !== 4'h0) begin n_fail++; $display("FAIL reset_dout: got %h want 0", dout); end
    n_checks++; if (dout_xz !== 4'h0) begin n_fail++; $display("FAIL reset_dout_xz: got %h want 0", dout_xz); end
    n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_evt_valid: got %b want 0", evt_valid); end
    n_checks++; if (xz_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_xz_cnt: got %0d want 0", xz_cnt); end
    n_checks++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_drop_cnt: got %0d want 0", drop_cnt); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    rst = 1'b0;
  endtask

  task automatic test_first_sample();
    tick();
    tick();
    tick();
    din = 4'hB;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    n_checks++; if (dout !== 4'hB) begin n_fail++; $display("FAIL first_dout: got %h want b", dout); end
    n_checks++; if (dout_xz !== 4'h0) begin n_fail++; $display("FAIL first_dout_xz: got %h want 0", dout_xz); end
    n_checks++; if (h_dout !== 4'hB) begin n_fail++; $display("FAIL first_h_dout: got %h want b", h_dout); end
    n_checks++; if (evt_valid !== 1'b1) begin n_fail++; $display("FAIL first_evt_valid: got %b want 1", evt_valid); end
    n_checks++; if ({evt_value, evt_xz, evt_ts} !== {4'hB, 4'h0, 8'd3})
      begin n_fail++; $display("FAIL first_record: got %h/%h/%0d want b/0/3", evt_value, evt_xz, evt_ts); end
    n_checks++; if (xz_cnt !== 8'd0) begin n_fail++; $display("FAIL first_xz_cnt: got %0d want 0", xz_cnt); end
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL first_pop: got evt_valid %b want 0", evt_valid); end
  endtask

  // If the simulator folds X/Z to 2-state, expectations follow the folded stimulus value.
  task automatic test_xz_fill();
    logic [3:0] pat, e_d, e_m, e_h;
    logic [7:0] e_c;
    bit fs, e_push;
    pat = 4'b1x0z;
    fs = (pat[2] !== 1'b0) && (pat[2] !== 1'b1);
    e_d = fs ? 4'b1000 : pat;
    e_m = fs ? 4'b0101 : 4'b0000;
    e_h = fs ? 4'b1001 : pat;
    e_c = fs ? 8'd1 : 8'd0;
    e_push = fs || (pat != 4'hB);
    din = pat;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    n_checks++; if (dout !== e_d) begin n_fail++; $display("FAIL xz_dout: got %b want %b", dout, e_d); end
    n_checks++; if (dout_xz !== e_m) begin n_fail++; $display("FAIL xz_mask: got %b want %b", dout_xz, e_m); end
    n_checks++; if (h_dout !== e_h) begin n_fail++; $display("FAIL xz_hold_dout: got %b want %b", h_dout, e_h); end
    n_checks++; if (xz_cnt !== e_c) begin n_fail++; $display("FAIL xz_cnt_1: got %0d want %0d", xz_cnt, e_c); end
    n_checks++; if (evt_valid !== e_push) begin n_fail++; $display("FAIL xz_push: got %b want %b", evt_valid, e_push); end
    if (e_push) begin
      n_checks++; if ({evt_value, evt_xz} !== {e_d, e_m})
        begin n_fail++; $display("FAIL xz_record: got %b/%b want %b/%b", evt_value, evt_xz, e_d, e_m); end
    end
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    e_c = fs ? 8'd2 : 8'd0;
    n_checks++; if (xz_cnt !== e_c) begin n_fail++; $display("FAIL xz_cnt_2: got %0d want %0d", xz_cnt, e_c); end
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL xz_repeat_no_record: got evt_valid %b want 0", evt_valid); end
  endtask

  task automatic test_hold_fill();
    logic [3:0] pat, e_d, e_m;
    logic [7:0] e_c;
    bit fs;
    din = 4'hF;
    din_valid = 1'b1;
    tick();
    pat = 4'bxxxx;
    fs = (pat[0] !== 1'b0) && (pat[0] !== 1'b1);
    e_d = fs ? 4'hF : pat;
    e_m = fs ? 4'hF : 4'h0;
    e_c = fs ? 8'd3 : 8'd0;
    din = pat;
    tick();
    din_valid = 1'b0;
    n_checks++; if (h_dout !== e_d) begin n_fail++; $display("FAIL hold_dout: got %b want %b", h_dout, e_d); end
    n_checks++; if (h_dout_xz !== e_m) begin n_fail++; $display("FAIL hold_mask: got %b want %b", h_dout_xz, e_m); end
    n_checks++; if (h_xz_cnt !== e_c) begin n_fail++; $display("FAIL hold_xz_cnt: got %0d want %0d", h_xz_cnt, e_c); end
    n_checks++; if ({h_evt_valid, h_evt_value, h_evt_xz} !== {1'b1, 4'hF, 4'h0})
      begin n_fail++; $display("FAIL hold_rec1: got %b/%h/%h want 1/f/0", h_evt_valid, h_evt_value, h_evt_xz); end
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    if (fs) begin
      n_checks++; if ({h_evt_valid, h_evt_value, h_evt_xz} !== {1'b1, 4'hF, 4'hF})
        begin n_fail++; $display("FAIL hold_rec2: got %b/%h/%h want 1/f/f", h_evt_valid, h_evt_value, h_evt_xz); end
    end
    // X/Z sample coinciding with clear: the clear must win.
    din_valid = 1'b1;
    clear = 1'b1;
    tick();
    din_valid = 1'b0;
    clear = 1'b0;
    n_checks++; if (xz_cnt !== 8'd0) begin n_fail++; $display("FAIL clear_wins: got %0d want 0", xz_cnt); end
    n_checks++; if (h_xz_cnt !== 8'd0) begin n_fail++; $display("FAIL clear_wins_h: got %0d want 0", h_xz_cnt); end
  endtask

  task automatic test_overflow();
    logic [7:0] t0;
    din = 4'hA;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    evt_ready = 1'b1;
    repeat (5) tick();
    evt_ready = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_start_empty: got %b want 0", evt_valid); end
    t0 = tb_ts;
    din_valid = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      din = 4'(k);
      tick();
    end
    din_valid = 1'b0;
    n_checks++; if (drop_cnt !== 8'd2) begin n_fail++; $display("FAIL ovf_drop_cnt: got %0d want 2", drop_cnt); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    n_checks++; if ({evt_valid, evt_value, evt_ts} !== {1'b1, 4'h1, t0})
      begin n_fail++; $display("FAIL ovf_head: got %b/%h/%0d want 1/1/%0d", evt_valid, evt_value, evt_ts, t0); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n_checks++; if ({drop_cnt, overflow} !== {8'd0, 1'b0})
      begin n_fail++; $display("FAIL ovf_clear: got %0d/%b want 0/0", drop_cnt, overflow); end
    n_checks++; if ({evt_valid, evt_value} !== {1'b1, 4'h1})
      begin n_fail++; $display("FAIL ovf_fifo_kept: got %b/%h want 1/1", evt_valid, evt_value); end
  endtask

  task automatic test_full_pop_push();
    logic [3:0] exp_q [4];
    exp_q = '{4'h2, 4'h3, 4'h4, 4'h7};
    din = 4'h7;
    din_valid = 1'b1;
    evt_ready = 1'b1;
    tick();
    din_valid = 1'b0;
    evt_ready = 1'b0;
    n_checks++; if ({drop_cnt, overflow} !== {8'd0, 1'b0})
      begin n_fail++; $display("FAIL full_pp_drop: got %0d/%b want 0/0", drop_cnt, overflow); end
    for (int k = 0; k < 4; k++) begin
      n_checks++; if ({evt_valid, evt_value} !== {1'b1, exp_q[k]})
        begin n_fail++; $display("FAIL full_pp_order%0d: got %b/%h want 1/%h", k, evt_valid, evt_value, exp_q[k]); end
      evt_ready = 1'b1;
      tick();
      evt_ready = 1'b0;
    end
    n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL full_pp_empty: got %b want 0", evt_valid); end
  endtask

  task automatic test_rst_mid_burst();
    din_valid = 1'b1;
    for (int k = 8; k <= 10; k++) begin
      din = 4'(k);
      tick();
    end
    din_valid = 1'b0;
    n_checks++; if ({evt_valid, evt_value} !== {1'b1, 4'h8})
      begin n_fail++; $display("FAIL rst_burst_queued: got %b/%h want 1/8", evt_valid, evt_value); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL rst_burst_flush: got %b want 0", evt_valid); end
    n_checks++; if (dout !== 4'h0) begin n_fail++; $display("FAIL rst_burst_dout: got %h want 0", dout); end
    din = 4'h0;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    n_checks++; if ({evt_valid, evt_value, evt_xz, evt_ts} !== {1'b1, 4'h0, 4'h0, 8'd0})
      begin n_fail++; $display("FAIL rst_armed_push: got %b/%h/%h/%0d want 1/0/0/0", evt_valid, evt_value, evt_xz, evt_ts); end
    n_checks++; if (h_evt_valid !== 1'b1) begin n_fail++; $display("FAIL rst_armed_push_h: got %b want 1", h_evt_valid); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_first_sample();
    test_xz_fill();
    test_hold_fill();
    test_overflow();
    test_full_pop_push();
    test_rst_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
